// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared state encoding, widths and helpers for the I2C init sequencer
package i2c_seq_pkg;

    localparam int CMD_W = 16;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BYTE0,
        S_BYTE1,
        S_WAIT_DONE,
        S_GAP,
        S_DONE
    } state_t;

    // Counter/index width able to hold 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// i2c_init_rom: power-up register-write table for the audio codec, indexed combinationally
module i2c_init_rom
    import i2c_seq_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] cmd_index,
    output logic [CMD_W-1:0] cmd_data
);

    logic [7:0] idx;

    assign idx = 8'(cmd_index);

    // Table lookup; unused indices read as zero
    always_comb begin
        case (idx)
            8'd0:    cmd_data = 16'h1E00;
            8'd1:    cmd_data = 16'h0C00;
            8'd2:    cmd_data = 16'h0E42;
            8'd3:    cmd_data = 16'h1017;
            8'd4:    cmd_data = 16'h0017;
            8'd5:    cmd_data = 16'h0217;
            8'd6:    cmd_data = 16'h0479;
            8'd7:    cmd_data = 16'h0679;
            8'd8:    cmd_data = 16'h0812;
            8'd9:    cmd_data = 16'h1201;
            default: cmd_data = 16'h0000;
        endcase
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks a register-write table, issuing each word to i2c_controller as a two-byte write.
// Defining I2C_SEQ_GAP_EN inserts a GAP_CYCLES idle period between consecutive commands.
module i2c_init_sequencer
    import i2c_seq_pkg::*;
#(
`ifdef I2C_SEQ_GAP_EN
    parameter int GAP_CYCLES = 1000,
`endif
    parameter int NUM_CMDS = 10,
    parameter logic [6:0] PERIPH_ADDR = 7'h1A,
    localparam int IDX_W = idx_width(NUM_CMDS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic [IDX_W-1:0] cmd_index,
    input  logic [CMD_W-1:0] cmd_data,
    input  logic             ctrl_ready,
    input  logic             ctrl_write_in_progress,
    output logic             ctrl_enable,
    output logic             ctrl_mode,
    output logic [6:0]       ctrl_periph_addr,
    output logic [7:0]       ctrl_input_byte,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);

    state_t           state_d, state_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [7:0]       byte_d, byte_q;
    logic             en_d, en_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             wip_q, rdy_q;
    logic             wip_rise, rdy_rise;

`ifdef I2C_SEQ_GAP_EN
    localparam int GAP_W = idx_width(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0] gap_d, gap_q;
`endif

    assign wip_rise = ctrl_write_in_progress & ~wip_q;
    assign rdy_rise = ctrl_ready & ~rdy_q;

    // Next-state logic: enable stays high through the hi-byte ACK and drops once the lo byte is latched
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef I2C_SEQ_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && ctrl_ready) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_LOAD: begin
                byte_d  = cmd_data[15:8];
                en_d    = 1'b1;
                state_d = S_BYTE0;
            end
            S_BYTE0: begin
                if (wip_rise) begin
                    byte_d  = cmd_data[7:0];
                    state_d = S_BYTE1;
                end
            end
            S_BYTE1: begin
                if (wip_rise) begin
                    en_d    = 1'b0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (rdy_rise) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
`ifdef I2C_SEQ_GAP_EN
                        state_d = S_GAP;
                        gap_d   = '0;
`else
                        state_d = S_LOAD;
`endif
                    end
                end
            end
`ifdef I2C_SEQ_GAP_EN
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_LOAD;
                else gap_d = gap_q + 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; controller handshakes sampled once for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            byte_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wip_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef I2C_SEQ_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wip_q   <= ctrl_write_in_progress;
            rdy_q   <= ctrl_ready;
`ifdef I2C_SEQ_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign cmd_index        = idx_q;
    assign ctrl_enable      = en_q;
    assign ctrl_input_byte  = byte_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign ctrl_mode        = MODE_WRITE;
    assign ctrl_periph_addr = PERIPH_ADDR;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: randomized bench pairing the sequencer with a behavioural byte-level I2C controller model
module tb_i2c_init_sequencer;

    localparam int N = 3;
    localparam int G = 20;
`ifdef I2C_SEQ_GAP_EN
    localparam int EXP_GAP = G + 2;
`else
    localparam int EXP_GAP = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cmd_index;
    logic [15:0] cmd_data;
    logic        ctrl_ready = 1'b1;
    logic        wip = 1'b0;
    logic        ctrl_enable;
    logic        ctrl_mode;
    logic [6:0]  ctrl_periph_addr;
    logic [7:0]  ctrl_input_byte;
    logic        busy;
    logic        done;
    logic [3:0]  rom_idx = '0;
    logic [15:0] rom_data;

    logic [15:0] words [4] = '{default: 16'h0000};

    int checks = 0;
    int failures = 0;

    // Controller model state
    bit         hold_rdy = 1'b0;
    int         m_ph = 0;
    int         tmr = 0;
    int         idle_cnt = 0;
    int         stops = 0;
    logic [7:0] q_bytes[$];
    logic [7:0] q_addr[$];
    int         q_idx[$];
    int         q_gap[$];

    assign cmd_data = words[cmd_index];

    i2c_init_sequencer #(
`ifdef I2C_SEQ_GAP_EN
        .GAP_CYCLES(G),
`endif
        .NUM_CMDS(N),
        .PERIPH_ADDR(7'h1A)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .cmd_index(cmd_index),
        .cmd_data(cmd_data),
        .ctrl_ready(ctrl_ready),
        .ctrl_write_in_progress(wip),
        .ctrl_enable(ctrl_enable),
        .ctrl_mode(ctrl_mode),
        .ctrl_periph_addr(ctrl_periph_addr),
        .ctrl_input_byte(ctrl_input_byte),
        .busy(busy),
        .done(done)
    );

    i2c_init_rom #(.IDX_W(4)) rom (
        .cmd_index(rom_idx),
        .cmd_data(rom_data)
    );

    always #5 clk = ~clk;

    // Byte-level controller: addr phase, bytes while enable holds at each ACK, STOP then ready
    always @(negedge clk) begin
        if (!reset_n) begin
            m_ph = 0;
            ctrl_ready = 1'b1;
            wip = 1'b0;
            idle_cnt = 0;
        end else begin
            case (m_ph)
                0: begin
                    ctrl_ready = !hold_rdy;
                    idle_cnt++;
                    if (ctrl_ready && ctrl_enable) begin
                        q_gap.push_back(idle_cnt);
                        q_idx.push_back(int'(cmd_index));
                        q_addr.push_back({ctrl_periph_addr, ~ctrl_mode});
                        ctrl_ready = 1'b0;
                        tmr = $urandom_range(3, 8);
                        m_ph = 1;
                    end
                end
                1, 3: begin
                    tmr--;
                    if (tmr == 0) begin
                        wip = 1'b1;
                        q_bytes.push_back(ctrl_input_byte);
                        tmr = $urandom_range(3, 8);
                        m_ph = 2;
                    end
                end
                2: begin
                    tmr--;
                    if (tmr == 0) begin
                        wip = 1'b0;
                        tmr = ctrl_enable ? $urandom_range(1, 3) : $urandom_range(2, 5);
                        m_ph = ctrl_enable ? 3 : 4;
                    end
                end
                default: begin
                    tmr--;
                    if (tmr == 0) begin
                        stops++;
                        ctrl_ready = 1'b1;
                        idle_cnt = 0;
                        m_ph = 0;
                    end
                end
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic clear_model();
        q_bytes.delete();
        q_addr.delete();
        q_idx.delete();
        q_gap.delete();
        stops = 0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ctrl_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_index !== 2'd0 || ctrl_input_byte !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: en=%b busy=%b done=%b idx=%0d byte=%h, need 0 0 0 0 00",
                     ctrl_enable, busy, done, cmd_index, ctrl_input_byte);
        end
        checks++;
        if (ctrl_mode !== 1'b1 || ctrl_periph_addr !== 7'h1A) begin
            failures++;
            $display("FAIL reset_const: mode=%b addr=%h, need 1 1a", ctrl_mode, ctrl_periph_addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rom();
        logic [15:0] tbl [10] = '{16'h1E00, 16'h0C00, 16'h0E42, 16'h1017, 16'h0017,
                                  16'h0217, 16'h0479, 16'h0679, 16'h0812, 16'h1201};
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            rom_idx = 4'(i);
            #1;
            exp = (i < 10) ? tbl[i] : 16'h0000;
            checks++;
            if (rom_data !== exp) begin
                failures++;
                $display("FAIL rom_entry[%0d]: got %h, need %h", i, rom_data, exp);
            end
        end
    endtask

    task automatic test_start_wait();
        bit ok;
        for (int i = 0; i < N; i++) words[i] = 16'($urandom);
        clear_model();
        hold_rdy = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ctrl_enable !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL start_no_ready: busy=%b en=%b done=%b, need 0 0 0", busy, ctrl_enable, done);
        end
        hold_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) break;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL start_after_ready: busy=%b, need 1", busy);
        end
        wait_done(ok);
        checks++;
        if (!ok || stops != N) begin
            failures++;
            $display("FAIL start_wait_run: done_seen=%0d stops=%0d, need 1 %0d", ok, stops, N);
        end
    endtask

    task automatic test_run(input int runs);
        bit ok;
        for (int r = 0; r < runs; r++) begin
            for (int i = 0; i < N; i++) words[i] = 16'($urandom);
            clear_model();
            repeat ($urandom_range(1, 4)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || cmd_index !== 2'd0) begin
                failures++;
                $display("FAIL run%0d_start: busy=%b done=%b idx=%0d, need 1 0 0", r, busy, done, cmd_index);
            end
            wait_done(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL run%0d_timeout: done=%b, need 1", r, done);
            end
            checks++;
            if (busy !== 1'b0 || cmd_index !== 2'(N - 1) || stops != N) begin
                failures++;
                $display("FAIL run%0d_end: busy=%b idx=%0d stops=%0d, need 0 %0d %0d", r, busy, cmd_index, stops, N - 1, N);
            end
            checks++;
            if (q_bytes.size() != 2 * N || q_idx.size() != N) begin
                failures++;
                $display("FAIL run%0d_counts: bytes=%0d cmds=%0d, need %0d %0d", r, q_bytes.size(), q_idx.size(), 2 * N, N);
            end
            for (int i = 0; i < N && 2 * i + 1 < q_bytes.size() && i < q_idx.size(); i++) begin
                checks++;
                if (q_bytes[2*i] !== words[i][15:8] || q_bytes[2*i+1] !== words[i][7:0] || q_idx[i] != i || q_addr[i] !== 8'h34) begin
                    failures++;
                    $display("FAIL run%0d_cmd%0d: addr=%h hi=%h lo=%h idx=%0d, need 34 %h %h %0d",
                             r, i, q_addr[i], q_bytes[2*i], q_bytes[2*i+1], q_idx[i], words[i][15:8], words[i][7:0], i);
                end
            end
            for (int i = 1; i < q_gap.size(); i++) begin
                checks++;
                if (q_gap[i] != EXP_GAP) begin
                    failures++;
                    $display("FAIL run%0d_gap%0d: ready-to-enable=%0d clks, need %0d", r, i, q_gap[i], EXP_GAP);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i < N; i++) words[i] = 16'($urandom);
        clear_model();
        start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (q_idx.size() >= 2) break;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || q_idx.size() != N) begin
            failures++;
            $display("FAIL held_start: done_seen=%0d cmds=%0d, need 1 %0d", ok, q_idx.size(), N);
        end
        for (int i = 0; i < q_idx.size(); i++) begin
            checks++;
            if (q_idx[i] != i) begin
                failures++;
                $display("FAIL held_start_idx%0d: got %0d, need %0d", i, q_idx[i], i);
            end
        end
        repeat ($urandom_range(5, 20)) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cmd_index !== 2'(N - 1)) begin
            failures++;
            $display("FAIL done_sticky: done=%b busy=%b idx=%0d, need 1 0 %0d", done, busy, cmd_index, N - 1);
        end
        clear_model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || cmd_index !== 2'd0) begin
            failures++;
            $display("FAIL restart: done=%b busy=%b idx=%0d, need 0 1 0", done, busy, cmd_index);
        end
        wait_done(ok);
        checks++;
        if (!ok || q_bytes.size() != 2 * N || stops != N) begin
            failures++;
            $display("FAIL rerun: done_seen=%0d bytes=%0d stops=%0d, need 1 %0d %0d", ok, q_bytes.size(), stops, 2 * N, N);
        end
    endtask

    task automatic test_reset_byte1();
        bit ok;
        for (int i = 0; i < N; i++) words[i] = 16'($urandom);
        clear_model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (q_bytes.size() >= 3) break;
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (ctrl_enable !== 1'b1 || busy !== 1'b1 || cmd_index !== 2'd1 || ctrl_input_byte !== words[1][7:0]) begin
            failures++;
            $display("FAIL pre_reset_byte1: en=%b busy=%b idx=%0d byte=%h, need 1 1 1 %h",
                     ctrl_enable, busy, cmd_index, ctrl_input_byte, words[1][7:0]);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ctrl_enable !== 1'b0 || busy !== 1'b0 || cmd_index !== 2'd0 || done !== 1'b0 || ctrl_input_byte !== 8'h00) begin
            failures++;
            $display("FAIL reset_byte1: en=%b busy=%b idx=%0d done=%b byte=%h, need 0 0 0 0 00",
                     ctrl_enable, busy, cmd_index, done, ctrl_input_byte);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || q_bytes.size() != 2 * N || (q_bytes.size() > 0 && q_bytes[0] !== words[0][15:8])) begin
            failures++;
            $display("FAIL recover: done_seen=%0d bytes=%0d, need 1 %0d", ok, q_bytes.size(), 2 * N);
        end
    endtask

    initial begin
        test_reset();
        test_rom();
        test_start_wait();
        test_run(4);
        test_back_to_back();
        test_reset_byte1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
